pwm_multi_channel: RTL

//  N-channel PWM timer, the parametrised successor of the single-channel PWM generator.
//  One shared period counter drives per-channel compare outputs.

---
 rtl/pwm_multi_channel_if.sv | 34 +++
 rtl/pwm_multi_channel.sv | 97 +++++++++
 2 files changed

// File: rtl/pwm_multi_channel_if.sv
// Control and output bundle of the multi-channel PWM timer.
// The master side (controller/bench) drives configuration; the slave side (timer) drives the pins.
interface pwm_multi_channel_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 32
);
  logic                  pwm_gen_en;
  logic                  center_mode;
  logic [CNT_W-1:0]      counter_arr;
  logic [CH*CNT_W-1:0]   counter_ccr;
  logic [CH-1:0]         pwm_pol;
  logic [CH-1:0]         pwm_out;
  logic                  period_tick;

  modport master (
    output pwm_gen_en,
    output center_mode,
    output counter_arr,
    output counter_ccr,
    output pwm_pol,
    input  pwm_out,
    input  period_tick
  );

  modport slave (
    input  pwm_gen_en,
    input  center_mode,
    input  counter_arr,
    input  counter_ccr,
    input  pwm_pol,
    output pwm_out,
    output period_tick
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// N-channel PWM timer: one shared period counter, per-channel compare and polarity,
// edge/centre alignment, and ARR/CCR/mode shadow registers reloaded at period boundaries.
module pwm_multi_channel #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 32
) (
  input logic                Clk,
  input logic                Rst_n,
  pwm_multi_channel_if.slave bus
);

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          arr_q, arr_d;
  logic [CH-1:0][CNT_W-1:0]  ccr_q, ccr_d;
  logic                      mode_q, mode_d;
  dir_e                      dir_q, dir_d;
  logic [CH-1:0]             pwm_q, pwm_d;
  logic                      tick_q, tick_d;

  logic                      arr_last;
  logic                      boundary;
  logic                      reload;

  assign arr_last = (cnt_q == (arr_q - CNT_W'(1)));

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    arr_d    = arr_q;
    ccr_d    = ccr_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    pwm_d    = bus.pwm_pol;
    boundary = 1'b0;
    reload   = 1'b0;

    if (!bus.pwm_gen_en || (arr_q == '0)) begin
      // Stopped or zero period: park the counter and keep shadows transparent.
      cnt_d  = '0;
      dir_d  = DirUp;
      reload = 1'b1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        pwm_d[i] = (cnt_q < ccr_q[i]) ^ bus.pwm_pol[i];
      end
      if (!mode_q) begin
        if (arr_last) boundary = 1'b1;
        else          cnt_d = cnt_q + CNT_W'(1);
      end else if (dir_q == DirUp) begin
        // Top of the triangle is held for one extra cycle while turning round.
        if (arr_last) dir_d = DirDown;
        else          cnt_d = cnt_q + CNT_W'(1);
      end else begin
        if (cnt_q == '0) boundary = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      if (boundary) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        dir_d  = DirUp;
        reload = 1'b1;
      end
    end

    if (reload) begin
      arr_d  = bus.counter_arr;
      ccr_d  = bus.counter_ccr;
      mode_d = bus.center_mode;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      dir_q  <= DirUp;
      arr_q  <= '0;
      ccr_q  <= '0;
      mode_q <= 1'b0;
      pwm_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      arr_q  <= arr_d;
      ccr_q  <= ccr_d;
      mode_q <= mode_d;
      pwm_q  <= pwm_d;
      tick_q <= tick_d;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_tick = tick_q;

endmodule
